// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: shared definitions for the RV32I load/store unit.
//   - funct3 encodings for loads and stores
//   - access size encodings (funct3[1:0])
//   - FSM state encoding
//   - helpers for byte enables, store lane replication and misalignment
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // size = funct3[1:0]; 2'b11 is treated as word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    if (sz[1])      return 4'b1111;
    else if (sz[0]) return 4'b0011 << {a[1], 1'b0};
    else            return 4'b0001 << a;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] wd);
    if (sz[1])      return wd;
    else if (sz[0]) return {2{wd[15:0]}};
    else            return {4{wd[7:0]}};
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz[1] & (|a)) | ((sz == SZ_HALF) & a[0]);
  endfunction

endpackage

// File: rtl/rv32i_load_store_unit_if.sv
// rv32i_load_store_unit_if: req/ack data-bus between the LSU (master) and
// data memory (slave).
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be : master -> slave
//   bus_ack/bus_rdata                        : slave -> master
interface rv32i_load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: combinational load-data alignment and extension.
//   i_rdata   : raw 32-bit word from the bus
//   i_addr_lo : byte offset within the word
//   i_func3   : load funct3 (size in [1:0], zero-extend in [2])
//   o_data    : aligned, sign/zero-extended result
module rv32i_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic        w_sext;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_sext    = ~i_func3[2];

  always_comb begin
    o_data = i_rdata;
    case (i_func3[1:0])
      SZ_BYTE: o_data = {{24{w_sext & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_data = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// rv32i_load_store_unit: multi-cycle load/store unit between the RV32I core
// and data memory. Accepts one access per ls_valid, runs one req/ack bus
// transaction, stalls the core meanwhile, and returns aligned load data.
//   sys_clk/sys_reset : clock, synchronous active-high reset
//   ls_*              : core side (request, store data, result, done/stall)
//   bus               : data bus master port
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned half/word accesses
// complete without a bus access and pulse ls_misaligned. Without it, the low
// address bits are forced to the access size.
module rv32i_load_store_unit
  import rv32i_lsu_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        ls_valid,
  input  logic        ls_store,
  input  logic [2:0]  ls_func3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        ls_stall,
  output logic        ls_misaligned,
  rv32i_load_store_unit_if.master bus
);

  lsu_state_e  r_state, w_next;
  logic        r_bus_req, r_store;
  logic [2:0]  r_func3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0]  r_bus_be;
  logic [1:0]  w_size, w_addr_lo;
  logic        w_mis, w_accept, w_ack;
  logic [31:0] w_load_data;

  assign w_size   = ls_func3[1:0];
  assign w_accept = (r_state == ST_IDLE) & ls_valid;
  assign w_ack    = (r_state == ST_REQ) & bus.bus_ack;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis     = misaligned(w_size, ls_addr[1:0]);
  assign w_addr_lo = ls_addr[1:0];

  always_ff @(posedge sys_clk) begin
    if (sys_reset)     r_mis <= 1'b0;
    else if (w_accept) r_mis <= w_mis;
  end
`else
  assign w_mis     = 1'b0;
  // Force the offset onto the natural boundary of the access size
  assign w_addr_lo = w_size[1] ? 2'b00 :
                     w_size[0] ? {ls_addr[1], 1'b0} : ls_addr[1:0];
`endif

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_reset) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // Next state; DONE ignores ls_valid so back-to-back accesses get an idle cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (ls_valid)     w_next = w_mis ? ST_DONE : ST_REQ;
      ST_REQ:  if (bus.bus_ack)  w_next = ST_DONE;
      ST_DONE:                   w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ls_done  = (r_state == ST_DONE);
    ls_stall = ls_valid & (r_state != ST_DONE);
`ifdef LSU_MISALIGN_TRAP_EN
    ls_misaligned = (r_state == ST_DONE) & r_mis;
`else
    ls_misaligned = 1'b0;
`endif
  end

  // Bus-side registers: latched on accept and held stable through REQ
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_bus_req   <= 1'b0;
      r_store     <= 1'b0;
      r_func3     <= '0;
      r_addr_lo   <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_rdata     <= '0;
    end else if (w_accept) begin
      r_bus_req   <= ~w_mis;
      r_store     <= ls_store;
      r_func3     <= ls_func3;
      r_addr_lo   <= w_addr_lo;
      r_bus_addr  <= {ls_addr[31:2], 2'b00};
      r_bus_wdata <= store_data(w_size, ls_wdata);
      r_bus_be    <= byte_en(w_size, w_addr_lo);
    end else if (w_ack) begin
      r_bus_req <= 1'b0;
      if (!r_store) r_rdata <= w_load_data;
    end
  end

  rv32i_load_align u_align (
    .i_rdata   (bus.bus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_func3   (r_func3),
    .o_data    (w_load_data)
  );

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_store;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_be    = r_bus_be;
  assign ls_rdata      = r_rdata;

endmodule
